// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one single-port, fixed-latency unified memory between the
// instruction fetch (IF) stage and the data memory (MEM) stage of a 5-stage
// pipeline. Data accesses win arbitration. A starvation counter forces a fetch
// grant once STARVE_MAX data grants have been made while fetch was waiting.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   if_req_i/if_addr_i              fetch request (held until if_ready_o)
//   if_ready_o/if_data_o            fetch completion pulse and instruction
//   dm_read_i/dm_write_i/dm_addr_i/dm_wdata_i   data request
//   dm_ready_o/dm_rdata_o           data completion pulse and read data
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o    memory command (en = 1 cycle)
//   mem_rdata_i                     memory read data, valid MEM_LAT after issue
//   stall_o                         pipeline stall while any requester waits
//   err_o                           sticky: read and write requested together
//   perf_stall_o                    stall-cycle counter
//
// Optional feature: define MEM_PORT_ARBITER_PERF_EN to build the saturating
// 16-bit stall-cycle counter; otherwise perf_stall_o is tied to zero.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              dm_read_i,
  input  logic              dm_write_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [15:0]       perf_stall_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C    = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  logic dm_req_s;
  logic if_done_s;
  logic dm_done_s;

  assign dm_req_s  = dm_read_i | dm_write_i;
  assign if_done_s = (state_q == BUSY_I) && (cnt_q == LAT_C);
  assign dm_done_s = (state_q == BUSY_D) && (cnt_q == LAT_C);

  // Arbitration, latency counting and command latching.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    en_d     = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        // Data wins unless fetch has already lost STARVE_MAX times in a row.
        if (dm_req_s && !(if_req_i && (starve_q == STARVE_C))) begin
          state_d = BUSY_D;
          en_d    = 1'b1;
          we_d    = dm_write_i;  // read+write together is treated as a write
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          cnt_d   = 4'd0;
          if (if_req_i) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (if_req_i) begin
          state_d  = BUSY_I;
          en_d     = 1'b1;
          we_d     = 1'b0;
          addr_d   = if_addr_i;
          cnt_d    = 4'd0;
          starve_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // Completion cycle always returns to IDLE for one arbitration cycle.
        if (cnt_q == LAT_C) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Read-data capture and sticky protocol error.
  always_comb begin
    if (if_done_s) begin
      if_data_d = mem_rdata_i;
    end else begin
      if_data_d = if_data_q;
    end
    // Writes complete with a ready pulse but leave the read data untouched.
    if (dm_done_s && !we_q) begin
      dm_rdata_d = mem_rdata_i;
    end else begin
      dm_rdata_d = dm_rdata_q;
    end
    err_d = err_q | (dm_read_i & dm_write_i);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      starve_q   <= 4'd0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  // The data outputs pass mem_rdata_i through in the completion cycle.
  assign if_ready_o  = if_done_s;
  assign dm_ready_o  = dm_done_s;
  assign if_data_o   = if_data_d;
  assign dm_rdata_o  = dm_rdata_d;
  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign stall_o     = (if_req_i && !if_done_s) || (dm_req_s && !dm_done_s);

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] perf_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= 16'd0;
    end else if (stall_o && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end else begin
      perf_q <= perf_q;
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2).
// Requester tasks push expected responses into per-port scoreboards; a
// negedge monitor pops them on every ready pulse. A cycle-arithmetic model of
// the arbitration rules predicts issue/ready cycles, stall and error flags.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'd0;
  logic        if_ready_o;
  logic [31:0] if_data_o;
  logic        dm_read_i = 1'b0;
  logic        dm_write_i = 1'b0;
  logic [31:0] dm_addr_i = 32'd0;
  logic [31:0] dm_wdata_i = 32'd0;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        stall_o;
  logic        err_o;
  logic [15:0] perf_stall_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_data_o(if_data_o),
    .dm_read_i(dm_read_i), .dm_write_i(dm_write_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o), .perf_stall_o(perf_stall_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference memory (what the program expects) and the physical memory the DUT drives.
  logic [31:0] ref_mem [0:127];
  logic [31:0] phys    [0:127];

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } dm_exp_t;

  logic [31:0] if_sb[$];
  dm_exp_t     dm_sb[$];
  logic [7:0]  log_q[$];

  // Memory responder: writes on issue, returns read data exactly LAT cycles later.
  int         rd_cyc = -1;
  logic [6:0] rd_idx = 7'd0;
  logic       rd_we = 1'b0;
  always @(negedge clk) begin
    if (mem_en_o) begin
      rd_cyc = cyc + LAT;
      rd_idx = mem_addr_o[8:2];
      rd_we  = mem_we_o;
      if (mem_we_o) phys[mem_addr_o[8:2]] = mem_wdata_o;
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc == rd_cyc && !rd_we) mem_rdata_i = phys[rd_idx];
      else mem_rdata_i = $urandom;
    end
  end

  // Arbitration model state, in absolute cycle numbers.
  int          if_done = -1;
  int          dm_done = -1;
  int          iss_cyc = -1;
  int          free_at = 0;
  int          starve_m = 0;
  logic [31:0] iss_addr = 32'd0;
  logic [31:0] iss_wdata = 32'd0;
  logic        iss_we = 1'b0;
  logic        err_m = 1'b0;
  logic [15:0] perf_m = 16'd0;
  logic [31:0] dm_last = 32'd0;

  // Monitor: compare this cycle, then advance the model.
  always @(negedge clk) begin
    logic    exp_stall;
    logic    dmp;
    logic    ifp;
    dm_exp_t e;
    if (rst_i) begin
      chk("rst_if_ready", if_ready_o, 1'b0);
      chk("rst_dm_ready", dm_ready_o, 1'b0);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_mem_wdata", mem_wdata_o, 32'd0);
      chk("rst_if_data", if_data_o, 32'd0);
      chk("rst_dm_rdata", dm_rdata_o, 32'd0);
      chk("rst_err", err_o, 1'b0);
      chk("rst_perf", perf_stall_o, 16'd0);
      if_done = -1; dm_done = -1; iss_cyc = -1; free_at = 0; starve_m = 0;
      err_m = 1'b0; perf_m = 16'd0; dm_last = 32'd0;
      if_sb.delete(); dm_sb.delete();
    end else begin
      dmp = dm_read_i | dm_write_i;
      ifp = if_req_i;
      chk("if_ready", if_ready_o, (cyc == if_done));
      chk("dm_ready", dm_ready_o, (cyc == dm_done));
      chk("mem_en", mem_en_o, (cyc == iss_cyc));
      if (iss_cyc >= 0 && cyc >= iss_cyc && cyc <= iss_cyc + LAT) begin
        chk("mem_addr", mem_addr_o, iss_addr);
        chk("mem_we", mem_we_o, iss_we);
        if (iss_we) chk("mem_wdata", mem_wdata_o, iss_wdata);
      end
      exp_stall = (ifp && (cyc != if_done)) || (dmp && (cyc != dm_done));
      chk("stall", stall_o, exp_stall);
      chk("err", err_o, err_m);
      chk("perf", perf_stall_o, perf_m);
`ifdef MEM_PORT_ARBITER_PERF_EN
      if (exp_stall && perf_m != 16'hFFFF) perf_m = perf_m + 16'd1;
`endif
      if (dm_read_i && dm_write_i) err_m = 1'b1;
      if (if_ready_o) begin
        log_q.push_back(8'h49);
        if (if_sb.size() == 0) chk("if_sb_empty", 1'b1, 1'b0);
        else chk("if_data", if_data_o, if_sb.pop_front());
      end
      if (dm_ready_o) begin
        log_q.push_back(8'h44);
        if (dm_sb.size() == 0) chk("dm_sb_empty", 1'b1, 1'b0);
        else begin
          e = dm_sb.pop_front();
          if (e.we) chk("dm_rdata_hold", dm_rdata_o, dm_last);
          else begin
            chk("dm_rdata", dm_rdata_o, e.data);
            dm_last = e.data;
          end
        end
      end
      // Arbitration decision made in this idle cycle takes effect next cycle.
      if (cyc >= free_at && (dmp || ifp)) begin
        if (dmp && !(ifp && starve_m == SMAX)) begin
          dm_done   = cyc + 1 + LAT;
          iss_addr  = dm_addr_i;
          iss_we    = dm_write_i;
          iss_wdata = dm_wdata_i;
          if (ifp) starve_m = starve_m + 1;
        end else begin
          if_done  = cyc + 1 + LAT;
          iss_addr = if_addr_i;
          iss_we   = 1'b0;
          starve_m = 0;
        end
        iss_cyc = cyc + 1;
        free_at = cyc + 2 + LAT;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input bit scramble);
    bit got = 1'b0;
    if_sb.push_back(ref_mem[addr[8:2]]);
    if_req_i  = 1'b1;
    if_addr_i = addr;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (if_ready_o) begin got = 1'b1; break; end
      if (scramble && mem_en_o) begin
        @(posedge clk);
        #1;
        if_addr_i = $urandom;
      end
    end
    if (!got) chk("if_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if_req_i  = 1'b0;
    if_addr_i = $urandom;
  endtask

  task automatic do_data(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble);
    bit      got = 1'b0;
    dm_exp_t e;
    e.we   = wr;
    e.data = wr ? 32'd0 : ref_mem[addr[8:2]];
    if (wr) ref_mem[addr[8:2]] = wdata;
    dm_sb.push_back(e);
    dm_read_i  = rd;
    dm_write_i = wr;
    dm_addr_i  = addr;
    dm_wdata_i = wdata;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dm_ready_o) begin got = 1'b1; break; end
      if (scramble && mem_en_o) begin
        @(posedge clk);
        #1;
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
      end
    end
    if (!got) chk("dm_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    dm_read_i  = 1'b0;
    dm_write_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = $urandom;
      phys[i]    = ref_mem[i];
    end
    ref_mem[4]  = 32'h00A00093; phys[4]  = 32'h00A00093;
    ref_mem[16] = 32'h00001234; phys[16] = 32'h00001234;
    idle(2);
    rst_i = 1'b0;
    idle(1);

    // Single fetch with the address changing after issue.
    do_fetch(32'h10, 1'b1);
    chk("if_data_hold", if_data_o, 32'h00A00093);
    idle(2);

    // Simultaneous fetch and load: load first.
    fork
      do_fetch(32'h10, 1'b0);
      do_data(1'b1, 1'b0, 32'h40, 32'd0, 1'b0);
    join
    chk("load_data_hold", dm_rdata_o, 32'h00001234);
    idle(2);

    // Starvation: fetch held against three back-to-back stores.
    log_q.delete();
    fork
      do_fetch(32'h20, 1'b0);
      begin
        do_data(1'b0, 1'b1, 32'h100, 32'h11111111, 1'b0);
        do_data(1'b0, 1'b1, 32'h104, 32'h22222222, 1'b0);
        do_data(1'b0, 1'b1, 32'h108, 32'h33333333, 1'b0);
      end
    join
    chk("starve_len", log_q.size(), 4);
    if (log_q.size() == 4)
      chk("starve_order", {log_q[0], log_q[1], log_q[2], log_q[3]}, {8'h44, 8'h44, 8'h49, 8'h44});
    idle(1);

    // Store then read back.
    do_data(1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 1'b1);
    do_data(1'b1, 1'b0, 32'h80, 32'd0, 1'b0);
    chk("store_readback", dm_rdata_o, 32'hDEADBEEF);
    idle(1);

    // Reset in cycle 2 of a fetch.
    if_req_i  = 1'b1;
    if_addr_i = 32'h14;
    idle(2);
    rst_i = 1'b1;
    #1;
    chk("async_rst_addr", mem_addr_o, 32'd0);
    chk("async_rst_ready", if_ready_o, 1'b0);
    if_req_i = 1'b0;
    idle(2);
    rst_i = 1'b0;
    idle(1);
    do_fetch(32'h14, 1'b0);
    idle(1);

    // Randomized concurrent traffic; data addresses kept apart from fetch addresses.
    fork
      for (int i = 0; i < 30; i++) begin
        idle($urandom_range(0, 3));
        do_fetch({23'd0, 1'b0, 6'($urandom_range(0, 63)), 2'b00}, 1'b0);
      end
      for (int j = 0; j < 30; j++) begin
        idle($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
          do_data(1'b1, 1'b0, {23'd0, 1'b1, 6'($urandom_range(0, 63)), 2'b00}, 32'd0, 1'b0);
        else
          do_data(1'b0, 1'b1, {23'd0, 1'b1, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 1'b0);
      end
    join
    idle(2);

    // Illegal read+write: performed as a write, error sticky until reset.
    chk("err_before", err_o, 1'b0);
    do_data(1'b1, 1'b1, 32'h180, 32'hCAFEF00D, 1'b0);
    do_data(1'b1, 1'b0, 32'h180, 32'd0, 1'b0);
    chk("rw_as_write", dm_rdata_o, 32'hCAFEF00D);
    idle(3);
    chk("err_sticky", err_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("err_cleared", err_o, 1'b0);
    idle(1);
    rst_i = 1'b0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
